// File: rtl/permute_arbiter.sv
// Time-shares one permute stage between NUM_CLIENTS hash contexts, handing the stage
// to one client for a whole message (all absorb blocks plus the squeeze), round-robin.
module permute_arbiter #(
    parameter int NUM_CLIENTS   = 2,
    parameter int RATE_SHAKE128 = 1344,
    parameter int IDX_W         = $clog2(NUM_CLIENTS)
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic [NUM_CLIENTS*RATE_SHAKE128-1:0] client_rate,
    input  logic [NUM_CLIENTS*32-1:0]            client_output_size,
    input  logic [NUM_CLIENTS*2-1:0]             client_mode,
    input  logic [NUM_CLIENTS-1:0]               client_ready,
    input  logic [NUM_CLIENTS-1:0]               client_last,
    input  logic [NUM_CLIENTS-1:0]               client_out_avail,
    input  logic [NUM_CLIENTS-1:0]               client_message_done,
    output logic [NUM_CLIENTS-1:0]               client_ready_clr,
    output logic [NUM_CLIENTS-1:0]               client_last_clr,
    output logic [NUM_CLIENTS-1:0]               client_out_we,

    output logic [RATE_SHAKE128-1:0]           stage_rate_input,
    output logic [31:0]                        stage_output_size,
    output logic [1:0]                         stage_mode,
    output logic                               stage_input_buffer_ready,
    output logic                               stage_last_block,
    output logic                               stage_output_buffer_available,
    input  logic                               stage_input_buffer_ready_clr,
    input  logic                               stage_last_block_clr,
    input  logic                               stage_output_buffer_we,

    output logic [NUM_CLIENTS-1:0]               grant,
    output logic                               busy,
    output logic                               protocol_error
);

    // state | meaning
    // IDLE  | no owner; arbitrate among client_ready starting at rr_ptr
    // BUSY  | owner is absorbing blocks through the stage
    // DRAIN | last block consumed; owner's squeeze runs until its message_done
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] owner_succ;
    logic             pick_valid;
    logic             owned;
    logic             owner_done;

    assign owned      = (state != IDLE);
    assign busy       = owned;
    assign owner_done = client_message_done[owner];
    assign owner_succ = (owner == IDX_W'(NUM_CLIENTS - 1)) ? '0 : owner + IDX_W'(1);

    // Scan downward so the lowest rotated distance from rr_ptr wins.
    always_comb begin
        int cand;
        cand       = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_CLIENTS) begin
                cand = cand - NUM_CLIENTS;
            end
            if (client_ready[IDX_W'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        stage_rate_input              = '0;
        stage_output_size             = '0;
        stage_mode                    = '0;
        stage_input_buffer_ready      = 1'b0;
        stage_last_block              = 1'b0;
        stage_output_buffer_available = 1'b0;
        grant                         = '0;
        client_ready_clr              = '0;
        client_last_clr               = '0;
        client_out_we                 = '0;
        if (owned) begin
            stage_rate_input              = client_rate[int'(owner)*RATE_SHAKE128 +: RATE_SHAKE128];
            stage_output_size             = client_output_size[int'(owner)*32 +: 32];
            stage_mode                    = client_mode[int'(owner)*2 +: 2];
            stage_output_buffer_available = client_out_avail[owner];
            // Input handshakes are blocked in DRAIN so a follow-on message waits for the squeeze.
            if (state == BUSY) begin
                stage_input_buffer_ready = client_ready[owner];
                stage_last_block         = client_last[owner];
            end
            grant[owner]            = 1'b1;
            client_ready_clr[owner] = stage_input_buffer_ready_clr;
            client_last_clr[owner]  = stage_last_block_clr;
            client_out_we[owner]    = stage_output_buffer_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            owner          <= '0;
            rr_ptr         <= '0;
            protocol_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stage_input_buffer_ready_clr || stage_last_block_clr ||
                        stage_output_buffer_we) begin
                        protocol_error <= 1'b1;
                    end
                    if (pick_valid) begin
                        owner <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (owner_done) begin
                        protocol_error <= 1'b1;
                    end
                    if (stage_last_block_clr) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (stage_input_buffer_ready_clr || stage_last_block_clr) begin
                        protocol_error <= 1'b1;
                    end
                    if (owner_done) begin
                        state  <= IDLE;
                        rr_ptr <= owner_succ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
